reset_sequencer: RTL

- Consumer end of the board reset generator's low-active reset line.
- Takes that reset request, plus PLL lock and memory-init status, and releases the per-subsystem resets (memory, video, CPU) in a fixed order with programmable gaps between them.
- Detects a stuck PLL or memory init with a timeout and flags it as a fault.
- Sits between the reset generator and all C64 core subsystems.

---
 rtl/reset_pkg.sv | 28 ++
 rtl/sync2.sv | 25 ++
 rtl/reset_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/reset_pkg.sv
// Shared types and defaults for the reset sequencer.
package reset_pkg;

  // System clock frequency the default timings are derived from.
  localparam int unsigned CLK_HZ = 10_000_000;

  // 100 us between consecutive subsystem releases.
  localparam int unsigned STAGE_DELAY_DEF = CLK_HZ / 10_000;

  // 100 ms ceiling on waiting for PLL lock or memory init.
  localparam int unsigned READY_TIMEOUT_DEF = CLK_HZ / 10;

  // Wide enough for both defaults above.
  localparam int unsigned CNT_W_DEF = 24;

  // Sequencer states; the encoding is exported unchanged on the stage port.
  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_WAIT_PLL = 3'd1,
    ST_DLY_MEM  = 3'd2,
    ST_WAIT_MEM = 3'd3,
    ST_DLY_VID  = 3'd4,
    ST_DLY_CPU  = 3'd5,
    ST_RUN      = 3'd6,
    ST_FAULT    = 3'd7
  } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level, reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Releases memory, video and CPU resets in order once the PLL is locked and
// memory init completes; flags a fault if either never becomes ready.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// HOLD     | all resets asserted, waiting for the reset request to lift
// WAIT_PLL | waiting for PLL lock, timeout running
// DLY_MEM  | lock seen, gap before releasing memory
// WAIT_MEM | memory released, waiting for init done, timeout running
// DLY_VID  | gap before releasing video
// DLY_CPU  | gap before releasing the CPU
// RUN      | everything released
// FAULT    | PLL or memory never became ready; parked until req drops
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int unsigned STAGE_DELAY   = STAGE_DELAY_DEF,
  parameter int unsigned READY_TIMEOUT = READY_TIMEOUT_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rst_req_n,
  input  logic       pll_locked,
  input  logic       mem_init_done,
  output logic       rst_mem,
  output logic       rst_video,
  output logic       rst_cpu,
  output logic       sys_ready,
  output logic       fault,
  output logic [2:0] stage
);

  localparam logic [CNT_W-1:0] STAGE_LAST   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(READY_TIMEOUT - 1);

  logic req;
  logic lock;

  sync2 u_sync_req (
    .clk (clk),
    .rst (reset),
    .d   (rst_req_n),
    .q   (req)
  );

  sync2 u_sync_lock (
    .clk (clk),
    .rst (reset),
    .d   (pll_locked),
    .q   (lock)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_mem_q, rst_mem_d;
  logic             rst_video_q, rst_video_d;
  logic             rst_cpu_q, rst_cpu_d;
  logic             sys_ready_q, sys_ready_d;
  logic             fault_q, fault_d;
  logic [2:0]       stage_q, stage_d;

  // Next state, counter and registered outputs; outputs only change on a
  // state transition, so FAULT keeps whatever reset pattern it arrived with.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rst_mem_d   = rst_mem_q;
    rst_video_d = rst_video_q;
    rst_cpu_d   = rst_cpu_q;
    sys_ready_d = sys_ready_q;
    fault_d     = fault_q;

    if (!req) begin
      state_d = ST_HOLD;
    end else if (!lock && (state_q inside {ST_DLY_MEM, ST_WAIT_MEM, ST_DLY_VID,
                                           ST_DLY_CPU, ST_RUN})) begin
      state_d = ST_HOLD;
    end else begin
      case (state_q)
        ST_HOLD:     state_d = ST_WAIT_PLL;
        ST_WAIT_PLL: begin
          if (lock)                      state_d = ST_DLY_MEM;
          else if (cnt_q == TIMEOUT_LAST) state_d = ST_FAULT;
        end
        ST_DLY_MEM:  if (cnt_q == STAGE_LAST) state_d = ST_WAIT_MEM;
        ST_WAIT_MEM: begin
          if (mem_init_done)             state_d = ST_DLY_VID;
          else if (cnt_q == TIMEOUT_LAST) state_d = ST_FAULT;
        end
        ST_DLY_VID:  if (cnt_q == STAGE_LAST) state_d = ST_DLY_CPU;
        ST_DLY_CPU:  if (cnt_q == STAGE_LAST) state_d = ST_RUN;
        default:     state_d = state_q;
      endcase
    end

    if (state_d != state_q) begin
      cnt_d = '0;
      case (state_d)
        ST_HOLD: begin
          rst_mem_d   = 1'b1;
          rst_video_d = 1'b1;
          rst_cpu_d   = 1'b1;
          sys_ready_d = 1'b0;
          fault_d     = 1'b0;
        end
        ST_WAIT_MEM: rst_mem_d   = 1'b0;
        ST_DLY_CPU:  rst_video_d = 1'b0;
        ST_RUN: begin
          rst_cpu_d   = 1'b0;
          sys_ready_d = 1'b1;
        end
        ST_FAULT: begin
          fault_d     = 1'b1;
          sys_ready_d = 1'b0;
        end
        default: ;
      endcase
    end else if (state_q != ST_HOLD && state_q != ST_RUN && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end

    stage_d = state_d;
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      rst_mem_q   <= 1'b1;
      rst_video_q <= 1'b1;
      rst_cpu_q   <= 1'b1;
      sys_ready_q <= 1'b0;
      fault_q     <= 1'b0;
      stage_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_mem_q   <= rst_mem_d;
      rst_video_q <= rst_video_d;
      rst_cpu_q   <= rst_cpu_d;
      sys_ready_q <= sys_ready_d;
      fault_q     <= fault_d;
      stage_q     <= stage_d;
    end
  end

  assign rst_mem   = rst_mem_q;
  assign rst_video = rst_video_q;
  assign rst_cpu   = rst_cpu_q;
  assign sys_ready = sys_ready_q;
  assign fault     = fault_q;
  assign stage     = stage_q;

endmodule
